// File: rtl/spi_sync_pkg.sv
// rtl/spi_sync_pkg.sv - shared constants and sizing helper for the SPI input synchroniser
package spi_sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_LEN_DEF  = 1;

  // Width of a counter that must hold 0..filter_len; never narrower than one bit
  function automatic int cnt_width(input int filter_len);
    int w;
    w = $clog2(filter_len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_input_sync_if.sv
// rtl/spi_input_sync_if.sv - pad-side inputs and filtered/edge outputs of the SPI input synchroniser
interface spi_input_sync_if #(
  parameter int WIDTH = 4
);

  logic             ena;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  // Driver of the pads/enable, consumer of the filtered value and pulses
  modport master (
    output ena,
    output data_in,
    input  data_out,
    input  rise,
    input  fall,
    input  changed
  );

  // The synchroniser itself
  modport slave (
    input  ena,
    input  data_in,
    output data_out,
    output rise,
    output fall,
    output changed
  );

endinterface

// File: rtl/spi_sync_bit.sv
// rtl/spi_sync_bit.sv - one bit: synchroniser chain, deglitch filter, output flop and edge pulses
module spi_sync_bit
  import spi_sync_pkg::*;
#(
  parameter int   STAGES     = SYNC_STAGES_DEF,
  parameter int   FILTER_LEN = FILTER_LEN_DEF,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ena_i,
  input  logic data_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_d_o
);

  localparam int             CW       = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  if (STAGES < 2) begin : g_stages_chk
    $error("spi_sync_bit: STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_filter_chk
    $error("spi_sync_bit: FILTER_LEN must be at least 1");
  end

  logic [STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              data_q, data_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              sync_out;

  // Only sync_q[0] ever samples the asynchronous pad; the rest is a plain shift
  assign sync_out = sync_q[STAGES-1];

  // Chain advances only on enabled edges
  always_comb begin
    sync_d = sync_q;
    if (ena_i) begin
      sync_d = {sync_q[STAGES-2:0], data_i};
    end
  end

  // Filter: a new chain value must persist FILTER_LEN enabled edges before adoption;
  // any return to the current output value before then discards the run
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (ena_i) begin
      if (sync_out == data_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        data_d = sync_out;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = data_d & ~data_q;
    fall_d = ~data_d & data_q;
  end

  // State registers; pulses are rebuilt every edge so they last exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      cnt_q  <= '0;
      data_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign data_o   = data_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign edge_d_o = rise_d | fall_d;

endmodule

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - WIDTH-bit SPI pad synchroniser with deglitch filter and edge pulses
module spi_input_sync
  import spi_sync_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = SYNC_STAGES_DEF,
  parameter int               FILTER_LEN = FILTER_LEN_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  spi_input_sync_if.slave  bus
);

  logic [WIDTH-1:0] data_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] edge_d_w;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    spi_sync_bit #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_VAL  (RESET_VAL[i])
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .ena_i    (bus.ena),
      .data_i   (bus.data_in[i]),
      .data_o   (data_w[i]),
      .rise_o   (rise_w[i]),
      .fall_o   (fall_w[i]),
      .edge_d_o (edge_d_w[i])
    );
  end

  assign changed_d = |edge_d_w;

  // Summary pulse registered on the same edge as the per-bit pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign bus.data_out = data_w;
  assign bus.rise     = rise_w;
  assign bus.fall     = fall_w;
  assign bus.changed  = changed_q;

endmodule

// File: doc/spi_input_sync.md
Name: spi_input_sync

Overview:
- Parametrised successor to the single-flop enable-gated reclocking register used on the SPI input path.
- Brings WIDTH asynchronous inputs into the clk domain through a STAGES-deep synchroniser chain.
- Applies a per-bit stability (deglitch) filter, then registers the filtered value.
- Emits one-cycle rise/fall pulses per bit. Sits between the SPI pads (sclk, cs, mosi) and the SPI protocol logic.

Parameters:
- WIDTH, 4, number of independent input bits (≥1).
- STAGES, 2, synchroniser flops per bit before the filter (≥2; elaboration assertion).
- FILTER_LEN, 1, consecutive enabled cycles a new synchronised value must persist before data_out adopts it (≥1; 1 = no filtering).
- RESET_VAL, '0 (WIDTH bits), reset value of chain flops and data_out.

Ports:
- clk  input  1  block clock.
- rst  input  1  asynchronous reset, active-high.
- ena  input  1  update enable; low freezes chain, counters and data_out.
- data_in  input  WIDTH  asynchronous inputs.
- data_out  output  WIDTH  synchronised, filtered value.
- rise  output  WIDTH  per-bit one-cycle pulse: data_out bit went 0→1.
- fall  output  WIDTH  per-bit one-cycle pulse: data_out bit went 1→0.
- changed  output  1  OR-reduction of (rise | fall), registered with them.

Behaviour:
- Reset: asynchronous on rst high, with no clock edge needed. Chain flops and data_out = RESET_VAL. Filter counters = 0. rise, fall, changed = 0. Because the chain resets to RESET_VAL, no spurious edge pulse follows reset release.
- Chain: on each posedge clk with ena=1, s[0] <= data_in and s[k] <= s[k-1]. With ena=0 all stages hold.
- Filter: per bit, counter cnt of width $clog2(FILTER_LEN+1), evaluated each enabled edge.
  - If s[STAGES-1][i] == data_out[i]: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: data_out[i] <= s[STAGES-1][i] and cnt <= 0.
  - Else: cnt <= cnt+1.
- Glitch rule: a mismatch lasting fewer than FILTER_LEN enabled cycles at the chain output never reaches data_out and leaves cnt at 0.
- Latency: a data_in step held stable, sampled at enabled edge 1, appears on data_out after enabled edge STAGES+FILTER_LEN. ena-low cycles add to the latency 1:1.
- Edge pulses: registered.
  - rise[i] <= 1 on the same edge data_out[i] goes 0→1; fall[i] likewise for 1→0.
  - All pulses clear on the next clk edge regardless of ena, so each pulse is exactly one clk cycle.
  - changed <= |(next rise | next fall), same timing.
- ena=0: no data_out change, so no pulses. A pulse already asserted still clears on the following edge.
- Simultaneous events: bits are independent. Rise on some bits and fall on others may assert in the same cycle.
- Counter never exceeds FILTER_LEN-1. For FILTER_LEN=1, cnt is constant 0 and may be optimised away.
- Metastability: only s[0] samples data_in. No logic between chain stages.

Decomposition:
- Package spi_sync_pkg: cnt_width function ($clog2(FILTER_LEN+1), minimum 1) and default constants SYNC_STAGES_DEF=2, FILTER_LEN_DEF=1.
- Sub-module spi_sync_bit: one bit's chain, filter counter, data_out flop and rise/fall flops, parametrised by STAGES, FILTER_LEN and a 1-bit reset value.
- Top level instantiates WIDTH copies in a generate loop and ORs the pulses into changed.

Test Plan:
- Reset (WIDTH=4, STAGES=2, FILTER_LEN=3, RESET_VAL=0): rst=1 with data_in=4'hF → data_out=0, rise/fall/changed=0 immediately. Release with data_in=0 held 20 cycles → no pulse ever.
- Step (ena=1): data_in 0→4'b0101 before edge 1, held → data_out=4'b0101 exactly after edge 5; rise=4'b0101 and changed=1 for one cycle; fall=0.
- Glitch: data_in[0] high for 2 cycles, then low → data_out[0] stays 0, rise[0] never asserts. Same bit high for 3 cycles → adopted, rise[0] pulses once.
- ena gating: step on bit2 with ena dropped for 10 cycles after the step reaches the chain output → data_out frozen during the gap; data_out[2] updates 3 enabled edges after the value reached the chain output.
- Async reset mid-filter: from data_out=4'b1111, start a 1→0 transition and assert rst between edges with cnt=1 → data_out=0 with no clock edge, no fall pulse. After release, chain value 0 matches data_out, so no pulses.
- Mixed edges: data_out=4'b0011, data_in→4'b1100 → after 5 edges data_out=4'b1100, rise=4'b1100, fall=4'b0011, changed=1 in the same single cycle.
